ifetch_unit: RTL and testbench

Instruction fetch stage of the RV32I pipeline: the producer side of the decode stage's instruction input. Holds the program counter, issues word reads to instruction memory over a request/grant/response handshake, and buffers returned words with their PCs in a 2-entry FIFO. It presents the buffered words to decode under a valid/stall handshake, and discards stale fetches when a branch or jump redirects the PC.

---
 rtl/ifetch_unit.sv | 112 +++++++++++
 tb/tb_ifetch_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// RV32I instruction fetch stage: PC sequencing, single-outstanding imem reads,
// 2-entry {pc, word} buffer toward decode, and redirect flush of stale fetches.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        inst_valid,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 2;
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, WAIT, KILL} state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] word;
    } fetch_entry_t;

    state_t             state;
    logic [XLEN-1:0]    fetch_pc;
    logic [XLEN-1:0]    req_pc;
    logic [XLEN-1:0]    last_pc;
    fetch_entry_t       fifo_q [DEPTH];
    logic               rd_ptr;
    logic               wr_ptr;
    logic [CNT_W-1:0]   count;

    logic               push;
    logic               pop;
    logic               grant;
    logic [CNT_W-1:0]   count_next;
    logic [XLEN-1:0]    redirect_word;

    assign redirect_word = redirect_pc & ~32'h0000_0003;

    // Issue decision: a new request may go out in the same cycle the previous response lands.
    always_comb begin
        push       = (state == WAIT) && imem_rvalid && !redirect;
        pop        = (count != '0) && !stall && !redirect;
        count_next = count + CNT_W'(push) - CNT_W'(pop);
        imem_req   = rst && !redirect && (count_next < CNT_W'(DEPTH))
                     && ((state == IDLE) || ((state == WAIT) && imem_rvalid));
        grant      = imem_req && imem_gnt;
    end

    assign imem_addr  = fetch_pc;
    assign inst_valid = (count != '0);
    assign inst_out   = inst_valid ? fifo_q[rd_ptr].word : NOP;
    assign pc_out     = inst_valid ? fifo_q[rd_ptr].pc   : last_pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            req_pc    <= RESET_PC;
            last_pc   <= RESET_PC;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            count     <= '0;
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
        end else begin
            if (count != '0) begin
                last_pc <= fifo_q[rd_ptr].pc;
            end
            // Redirect wins over push, pop and grant; an in-flight grant becomes a kill.
            if (redirect) begin
                fetch_pc <= redirect_word;
                count    <= '0;
                rd_ptr   <= 1'b0;
                wr_ptr   <= 1'b0;
                case (state)
                    WAIT:    state <= imem_rvalid ? IDLE : KILL;
                    KILL:    state <= imem_rvalid ? IDLE : KILL;
                    default: state <= IDLE;
                endcase
            end else begin
                if (push) begin
                    fifo_q[wr_ptr] <= '{pc: req_pc, word: imem_rdata};
                    wr_ptr         <= ~wr_ptr;
                end
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                end
                count <= count_next;
                if (grant) begin
                    req_pc   <= fetch_pc;
                    fetch_pc <= fetch_pc + 32'd4;
                end
                case (state)
                    IDLE:    if (grant) state <= WAIT;
                    WAIT:    if (imem_rvalid) state <= grant ? WAIT : IDLE;
                    KILL:    if (imem_rvalid) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboarded bench for ifetch_unit: a latency-programmable memory model answers
// grants, expected {pc, word} pairs are queued per phase and checked on each pop.
module tb_ifetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata  = 32'h0;
    logic        redirect    = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        stall       = 1'b0;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] pc_out;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t        exp_q [$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          lat     = 1;
    logic        gnt_en  = 1'b1;
    logic        pend_valid = 1'b0;
    logic [31:0] pend_addr  = 32'h0;
    int          pend_cnt   = 0;

    assign imem_gnt = gnt_en;

    ifetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .inst_valid  (inst_valid),
        .inst_out    (inst_out),
        .pc_out      (pc_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'h0:   return 32'h00A0_0093;
            32'h4:   return 32'h0010_0113;
            32'h8:   return 32'h0020_81B3;
            32'hC:   return 32'h0000_0013;
            default: return {16'hCAFE, addr[15:0]};
        endcase
    endfunction

    task automatic push_seq(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.pc   = start + 32'(4 * i);
            e.word = mem_word(e.pc);
            exp_q.push_back(e);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Memory model: latches a grant at the edge, answers after `lat` cycles.
    always @(posedge clk) begin
        if (imem_rvalid) pend_valid = 1'b0;
        if (imem_req && imem_gnt) begin
            pend_valid = 1'b1;
            pend_addr  = imem_addr;
            pend_cnt   = lat;
        end
        #1;
        imem_rvalid = 1'b0;
        if (pend_valid) begin
            pend_cnt--;
            if (pend_cnt <= 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(pend_addr);
            end
        end
    end

    // Monitor: every accepted instruction must match the head of the expected queue.
    always @(negedge clk) begin
        if (inst_valid && !stall && !redirect) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_inst: got pc %h inst %h, expected none", pc_out, inst_out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (pc_out !== e.pc || inst_out !== e.word) begin
                    n_fail++;
                    $display("FAIL inst_stream: got pc %h inst %h, expected pc %h inst %h",
                             pc_out, inst_out, e.pc, e.word);
                end
            end
        end
    end

    initial begin
        logic found;

        // Reset held with random inputs
        for (int i = 0; i < 3; i++) begin
            cyc();
            stall       = 1'($urandom);
            redirect    = 1'($urandom);
            redirect_pc = $urandom;
            @(negedge clk);
            check("rst_req",   32'(imem_req),   32'h0);
            check("rst_valid", 32'(inst_valid), 32'h0);
            check("rst_inst",  inst_out,        32'h13);
            check("rst_pc",    pc_out,          32'h0);
        end

        // Zero-wait streaming
        exp_q.push_back('{32'h0, 32'h00A0_0093});
        exp_q.push_back('{32'h4, 32'h0010_0113});
        exp_q.push_back('{32'h8, 32'h0020_81B3});
        exp_q.push_back('{32'hC, 32'h0000_0013});
        push_seq(32'h10, 40);
        cyc();
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        @(negedge clk);
        check("first_req",  32'(imem_req), 32'h1);
        check("first_addr", imem_addr,     32'h0);
        cyc(); @(negedge clk);
        check("valid_cycle1", 32'(inst_valid), 32'h0);
        cyc(); @(negedge clk);
        check("valid_cycle2", 32'(inst_valid), 32'h1);
        repeat (4) cyc();

        // Stall saturates the buffer; head word must be held
        stall = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i >= 1) begin
                check("stall_req",   32'(imem_req),   32'h0);
                check("stall_valid", 32'(inst_valid), 32'h1);
                if (exp_q.size() > 0) check("stall_hold", inst_out, exp_q[0].word);
            end
            cyc();
        end
        stall = 1'b0;
        @(negedge clk);
        check("unstall_req", 32'(imem_req), 32'h1);
        repeat (8) cyc();

        // 3-cycle memory, redirect one cycle after the grant at 0x8
        rst = 1'b0; exp_q.delete(); lat = 3;
        repeat (2) cyc();
        rst = 1'b1;
        push_seq(32'h0, 40);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (imem_req && imem_gnt && imem_addr == 32'h8) found = 1'b1;
            cyc();
        end
        check("grant_at_8_seen", 32'(found), 32'h1);
        redirect = 1'b1; redirect_pc = 32'h100;
        exp_q.delete();
        push_seq(32'h100, 40);
        @(negedge clk);
        check("redir_req_low", 32'(imem_req), 32'h0);
        cyc();
        redirect = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            check("redir_valid_low", 32'(inst_valid), 32'h0);
            if (imem_req) found = 1'b1;
            else cyc();
        end
        check("redir_req_seen", 32'(found), 32'h1);
        check("redir_addr",     imem_addr,  32'h100);
        repeat (12) cyc();

        // Redirect together with stall while the buffer is full
        lat = 1; stall = 1'b1;
        repeat (8) cyc();
        @(negedge clk);
        check("full_valid", 32'(inst_valid), 32'h1);
        check("full_req",   32'(imem_req),   32'h0);
        cyc();
        redirect = 1'b1; redirect_pc = 32'h203;
        exp_q.delete();
        push_seq(32'h200, 40);
        @(negedge clk);
        check("redir2_req_low", 32'(imem_req), 32'h0);
        cyc();
        redirect = 1'b0; stall = 1'b0;
        @(negedge clk);
        check("redir2_empty", 32'(inst_valid), 32'h0);
        check("redir2_req",   32'(imem_req),   32'h1);
        check("redir2_addr",  imem_addr,       32'h200);
        repeat (8) cyc();

        // Reset with a grant outstanding; the late response must be ignored
        lat = 3;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (imem_req && imem_gnt) found = 1'b1;
            cyc();
        end
        check("grant_before_rst", 32'(found), 32'h1);
        rst = 1'b0; gnt_en = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("midrst_req",   32'(imem_req),   32'h0);
        check("midrst_valid", 32'(inst_valid), 32'h0);
        cyc();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stale_valid", 32'(inst_valid), 32'h0);
            check("restart_req", 32'(imem_req),   32'h1);
            check("restart_addr", imem_addr,      32'h0);
            cyc();
        end
        gnt_en = 1'b1; lat = 1;
        push_seq(32'h0, 40);
        repeat (10) cyc();
        check("restart_drained", 32'(exp_q.size() < 35), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end
endmodule
